// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler: radix-2 DIT address/twiddle sequencer with write-back delay line; FFT_SCHED_LOAD_EN adds a bit-reversed LOAD phase
module fft_stage_scheduler #(
  parameter int N = 16,
  parameter int BF_LATENCY = 2,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             issue_ready,
`ifdef FFT_SCHED_LOAD_EN
  input  logic             in_valid,
  output logic             load_we,
  output logic [LOG2N-1:0] load_addr,
`endif
  output logic             busy,
  output logic             done,
  output logic             issue_valid,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-1:0] stage_idx
);
  localparam int PW = LOG2N - 1;
  localparam int DW = $clog2(BF_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
`ifdef FFT_SCHED_LOAD_EN
  localparam state_t FIRST = LOAD;
`else
  localparam state_t FIRST = ISSUE;
`endif
  state_t state, state_nx;
  logic [LOG2N-1:0] stage, pair_ext, half, pos, grp, addr_a, addr_b, tw_sh, tw_full;
  logic [PW-1:0] pair;
  logic [DW-1:0] dcnt;
  logic accept, last_pair, last_stage, drain_end;
  logic sr_v [BF_LATENCY];
  logic [LOG2N-1:0] sr_a [BF_LATENCY];
  logic [LOG2N-1:0] sr_b [BF_LATENCY];
`ifdef FFT_SCHED_LOAD_EN
  logic [LOG2N-1:0] lcnt, lrev;
  assign lrev = {<<{lcnt}};
`endif
  assign accept = (state == ISSUE) && issue_ready;
  assign last_pair = pair == PW'(N / 2 - 1);
  assign last_stage = stage == LOG2N'(LOG2N - 1);
  assign drain_end = dcnt == DW'(BF_LATENCY - 1);
  // butterfly pair addressing for the current stage and pair index
  always_comb begin
    pair_ext = {1'b0, pair};
    half = LOG2N'(1) << stage;
    pos = pair_ext & (half - 1'b1);
    grp = pair_ext >> stage;
    addr_a = (grp << (stage + 1'b1)) | pos;
    addr_b = addr_a + half;
    tw_sh = LOG2N'(PW) - stage;
    tw_full = pos << tw_sh;
  end
  // next-state logic: each stage issues all pairs, then drains the butterfly pipeline
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? FIRST : IDLE;
`ifdef FFT_SCHED_LOAD_EN
      LOAD:  state_nx = (in_valid && lcnt == '1) ? ISSUE : LOAD;
`endif
      ISSUE: state_nx = (accept && last_pair) ? DRAIN : ISSUE;
      DRAIN: state_nx = drain_end ? (last_stage ? DONE : ISSUE) : DRAIN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // pair, drain and stage counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
      pair <= '0;
      dcnt <= '0;
    end else begin
      pair <= accept ? pair + 1'b1 : pair;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (state == DONE) stage <= '0;
      else if (state == DRAIN && drain_end && !last_stage) stage <= stage + 1'b1;
    end
  end
  // write-back delay line matching butterfly latency; free-running so stalls never skew it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        sr_v[i] <= 1'b0;
        sr_a[i] <= '0;
        sr_b[i] <= '0;
      end
    end else begin
      sr_v[0] <= accept;
      sr_a[0] <= addr_a;
      sr_b[0] <= addr_b;
      for (int i = 1; i < BF_LATENCY; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_a[i] <= sr_a[i-1];
        sr_b[i] <= sr_b[i-1];
      end
    end
  end
`ifdef FFT_SCHED_LOAD_EN
  // input sample loader: writes arriving samples to bit-reversed RAM addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt <= '0;
      load_we <= 1'b0;
      load_addr <= '0;
    end else begin
      lcnt <= (state == LOAD) ? (in_valid ? lcnt + 1'b1 : lcnt) : '0;
      load_we <= (state == LOAD) && in_valid;
      load_addr <= ((state == LOAD) && in_valid) ? lrev : load_addr;
    end
  end
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign issue_valid = state == ISSUE;
  assign rd_addr_a = issue_valid ? addr_a : '0;
  assign rd_addr_b = issue_valid ? addr_b : '0;
  assign tw_addr = issue_valid ? tw_full[PW-1:0] : '0;
  assign wr_en = sr_v[BF_LATENCY-1];
  assign wr_addr_a = sr_a[BF_LATENCY-1];
  assign wr_addr_b = sr_b[BF_LATENCY-1];
  assign stage_idx = stage;
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// tb_fft_stage_scheduler: scoreboard and vector-table bench for fft_stage_scheduler
module tb_fft_stage_scheduler;
  localparam int N = 16;
  localparam int BFL = 2;
  localparam int LOG2N = 4;
  localparam int NP = N / 2;
`ifdef FFT_SCHED_LOAD_EN
  localparam int LDLAT = N;
`else
  localparam int LDLAT = 0;
`endif
  logic clk = 0, rst = 1, start = 0, issue_ready = 1;
  logic busy, done, issue_valid, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage_idx;
  logic [LOG2N-2:0] tw_addr;
`ifdef FFT_SCHED_LOAD_EN
  logic in_valid = 1, load_we;
  logic [LOG2N-1:0] load_addr;
`endif
  fft_stage_scheduler #(.N(N), .BF_LATENCY(BFL)) dut (
    .clk(clk), .rst(rst), .start(start), .issue_ready(issue_ready),
`ifdef FFT_SCHED_LOAD_EN
    .in_valid(in_valid), .load_we(load_we), .load_addr(load_addr),
`endif
    .busy(busy), .done(done), .issue_valid(issue_valid),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage_idx(stage_idx)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r |= ((v >> i) & 1) << (LOG2N - 1 - i);
    return r;
  endfunction
  typedef struct {int a; int b; int due;} wr_t;
  wr_t q[$];
  wr_t w;
  int ms, mp, wr_cnt, acc_cnt, done_cnt, lc;
  int h, ea, eb, et;
  int obs_a[LOG2N][NP], obs_b[LOG2N][NP], obs_t[LOG2N][NP];
  logic held_v = 0;
  int held_a, held_b, held_t;
  task automatic reset_model();
    ms = 0; mp = 0; wr_cnt = 0; acc_cnt = 0; done_cnt = 0; lc = 0;
    q.delete();
  endtask
  always @(negedge clk) begin
    if (issue_valid && held_v) begin
      chk("hold_rd_a", rd_addr_a, held_a);
      chk("hold_rd_b", rd_addr_b, held_b);
      chk("hold_tw", tw_addr, held_t);
    end
    held_v = issue_valid && !issue_ready;
    held_a = rd_addr_a; held_b = rd_addr_b; held_t = tw_addr;
    if (issue_valid && issue_ready) begin
      h = 1 << ms;
      ea = (mp / h) * 2 * h + mp % h;
      eb = ea + h;
      et = (mp % h) * (NP / h);
      if (mp == 0 && ms > 0) chk("raw_drained_before_stage", q.size(), 0);
      chk("rd_addr_a", rd_addr_a, ea);
      chk("rd_addr_b", rd_addr_b, eb);
      chk("tw_addr", tw_addr, et);
      chk("stage_idx", stage_idx, ms);
      if (ms < LOG2N) begin
        obs_a[ms][mp] = rd_addr_a; obs_b[ms][mp] = rd_addr_b; obs_t[ms][mp] = tw_addr;
      end
      q.push_back('{ea, eb, cyc + BFL});
      acc_cnt++; mp++;
      if (mp == NP) begin mp = 0; ms++; end
    end
    if (wr_en) begin
      wr_cnt++;
      if (q.size() == 0) chk("wr_en_unexpected", 1, 0);
      else begin
        w = q.pop_front();
        chk("wr_addr_a", wr_addr_a, w.a);
        chk("wr_addr_b", wr_addr_b, w.b);
        chk("wr_cycle", cyc, w.due);
      end
    end
    if (done) done_cnt++;
`ifdef FFT_SCHED_LOAD_EN
    if (load_we) begin chk("load_addr", load_addr, brev(lc)); lc++; end
`endif
  end
  // mode 0: no stalls; 1: issue_ready low on odd cycles; 2: extra start pulses while busy
  task automatic run(input int mode, output int dcyc);
    int ts;
    dcyc = -1;
    reset_model();
    @(posedge clk); #1;
    start = 1; issue_ready = 1; ts = cyc + LDLAT;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = (mode == 2) && (cyc - ts == 20 || cyc - ts == 35);
      issue_ready = (mode != 1) || ((cyc - ts) % 2 == 0);
      if (done) begin dcyc = cyc - ts; break; end
    end
    start = 0; issue_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("accepts", acc_cnt, NP * LOG2N);
    chk("writes", wr_cnt, NP * LOG2N);
    chk("pending_writes", q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask
  typedef struct {int s; int p; int a; int b; int tw;} vec_t;
  vec_t tbl[12];
  int dc, wsnap;
  initial begin
    tbl[0]  = '{0, 0, 0, 1, 0};   tbl[1]  = '{0, 1, 2, 3, 0};
    tbl[2]  = '{0, 7, 14, 15, 0}; tbl[3]  = '{1, 1, 1, 3, 4};
    tbl[4]  = '{1, 2, 4, 6, 0};   tbl[5]  = '{1, 7, 13, 15, 4};
    tbl[6]  = '{2, 5, 9, 13, 2};  tbl[7]  = '{2, 3, 3, 7, 6};
    tbl[8]  = '{3, 0, 0, 8, 0};   tbl[9]  = '{3, 1, 1, 9, 1};
    tbl[10] = '{3, 7, 7, 15, 7};  tbl[11] = '{3, 4, 4, 12, 4};
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr_b", rd_addr_b, 0);
    chk("rst_stage_idx", stage_idx, 0);
    rst = 0;
    run(0, dc);
    chk("done_cycle_nostall", dc, 41);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_rd_a", i), obs_a[tbl[i].s][tbl[i].p], tbl[i].a);
      chk($sformatf("tbl%0d_rd_b", i), obs_b[tbl[i].s][tbl[i].p], tbl[i].b);
      chk($sformatf("tbl%0d_tw", i), obs_t[tbl[i].s][tbl[i].p], tbl[i].tw);
    end
    run(1, dc);
    chk("done_cycle_stall", dc, 73);
    run(2, dc);
    chk("done_cycle_start_busy", dc, 41);
    reset_model();
    @(posedge clk); #1;
    start = 1;
    dc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 0;
      if (stage_idx == 1 && issue_valid) begin dc = 1; break; end
    end
    chk("reached_stage1", dc, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    q.delete();
    wsnap = wr_cnt;
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_writes", wr_cnt, wsnap);
    run(0, dc);
    chk("done_cycle_after_rst", dc, 41);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
